// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot decoder with direct and auto-scan modes (option macro: ONEHOT_ACTIVE_LOW_EN)
module onehot_scan_decoder #(
    parameter int IN_W    = 4,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = 2**IN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic [IN_W-1:0]    binary_in,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [IN_W-1:0]    scan_last,
    output logic [OUT_W-1:0]   decoder_out,
    output logic [IN_W-1:0]    index_out,
    output logic               valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Polarity mask folded into the output register so decoder_out stays a pure flop output.
`ifdef ONEHOT_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] DEC_POL = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] DEC_POL = {OUT_W{1'b0}};
`endif

    localparam logic [OUT_W-1:0] DEC_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    state_t             state_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic [IN_W-1:0]    idx_d;
    logic               valid_d;
    logic               wrap_d;
    logic [OUT_W-1:0]   dec_d;

    // Next state and next registered outputs; the state chosen for the coming cycle drives the outputs.
    always_comb begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (enable) begin
            state_d = mode ? ST_SCAN : ST_DIRECT;
        end

        case (state_d)
            ST_DIRECT: begin
                idx_d   = binary_in;
                valid_d = 1'b1;
            end
            ST_SCAN: begin
                valid_d = 1'b1;
                // Entering from another state leaves idx/cnt at zero.
                if (state_q == ST_SCAN) begin
                    // >= so a live lowering of dwell below the running count advances at once.
                    if (cnt_q >= dwell) begin
                        // >= also catches scan_last lowered beneath the current index.
                        if (index_out >= scan_last) begin
                            idx_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = index_out + IN_W'(1);
                        end
                    end else begin
                        idx_d = index_out;
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase

        dec_d = valid_d ? (DEC_ONE << idx_d) : '0;
    end

    // State, dwell counter and all outputs registered; async reset forces the idle picture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            index_out   <= '0;
            valid       <= 1'b0;
            wrap        <= 1'b0;
            decoder_out <= DEC_POL;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            index_out   <= idx_d;
            valid       <= valid_d;
            wrap        <= wrap_d;
            decoder_out <= dec_d ^ DEC_POL;
        end
    end

endmodule
